map_server: RTL and testbench
=============================

# map_server

Tile-map storage and lookup responder for the tank game. It answers the VGA renderer's per-tile wall requests and the game logic's collision queries, and it applies shell hits that damage or destroy brick tiles. It sits between `VGA` (request x/y and busy) and `state`/`shell` (collision and hit traffic), all on the 25 MHz game clock. It replaces the static wall lookup with a destructible map that is rebuilt on every new game.

## Interface
- `MAP_W`, default 40: map width in tiles.
- `MAP_H`, default 30: map height in tiles.
- `clk` — in, 1: game clock (CLOCK_25).
- `rst_n` — in, 1: asynchronous active-low reset.
- `i_reload` — in, 1: single-cycle pulse that rebuilds the map (new game).
- `i_busy` — in, 1: VGA frame-draw in progress. Map writes are blocked while high.
- `i_req_x`, `i_req_y` — in, 6: VGA tile request.
- `o_is_wall` — out, 1: requested tile is non-empty.
- `o_tile` — out, 2: requested tile type.
  - 0 empty, 1 brick with 1 HP, 2 brick with 2 HP, 3 steel.
- `i_q_x`, `i_q_y` — in, 6: collision query tile.
- `o_q_wall` — out, 1: query tile is non-empty.
- `i_hit_valid` — in, 1: shell hit request.
- `i_hit_x`, `i_hit_y` — in, 6: hit tile.
- `o_hit_ready` — out, 1: hit port can accept.
- `o_hit_ack` — out, 1: one-cycle pulse, hit processed.
- `o_hit_absorbed` — out, 1: shell stopped (tile was non-empty). Valid only with `o_hit_ack`.
- `o_init_done` — out, 1: map build complete.

## Operation
- Storage: MAP_H rows × MAP_W tiles × 2 bits, held in flops.
- Any coordinate with x ≥ MAP_W or y ≥ MAP_H reads as steel (3) on every port.
- Build pattern, applied in priority order:
  - Steel where x==0, y==0, x==MAP_W-1 or y==MAP_H-1.
  - Else steel where x%10==5 and y%10==5.
  - Else brick-2 where y%6==3 and x%4!=0.
  - Else empty.
- FSM states: INIT, RUN.
  - Reset → INIT with row counter 0.
  - INIT: each cycle writes one full row, then increments the row counter.
  - After row MAP_H-1 is written → RUN, and `o_init_done` is set to 1.
  - `i_reload` in any state → INIT with row counter 0 and `o_init_done`=0. A reload during INIT restarts from row 0.
  - While in INIT, rows not yet rewritten keep their old contents.
- Read ports (VGA and query) are independent and always active. Each output is a registered lookup of the address from the previous cycle.
  - `o_is_wall` = (`o_tile` != 0).
  - `o_q_wall` = (tile != 0).
- Hit handshake:
  - `o_hit_ready` = RUN && !`i_busy` && !`i_reload`.
  - A hit is accepted on an edge where `i_hit_valid` && `o_hit_ready`. Only one hit can be accepted per cycle.
  - On acceptance, read-modify-write of the tile:
    - brick-2 → brick-1
    - brick-1 → empty
    - steel / empty / out-of-range: unchanged
  - `o_hit_absorbed` = (old tile != 0), including the out-of-range case.
  - `i_hit_valid` with `o_hit_ready` low: the request is not accepted. The requester holds it.
- Read and accepted hit on the same tile in the same cycle: the read returns the pre-hit value. The next read returns the updated value.

## Timing
- Reset values:
  - `o_is_wall` 0, `o_tile` 0, `o_q_wall` 0
  - `o_hit_ack` 0, `o_hit_absorbed` 0
  - `o_init_done` 0, `o_hit_ready` 0
  - storage all 0, FSM INIT, row counter 0
- Build time:
  - Row r is written on the (r+1)-th rising edge after `rst_n` rises.
  - `o_init_done` rises on edge MAP_H, which is edge 30 by default.
- Read latency: 1 cycle, address to `o_tile`/`o_q_wall`, at full throughput.
- Hit latency: acceptance edge N.
  - Tile updated and `o_hit_ack`/`o_hit_absorbed` valid after edge N.
  - `o_hit_ack` is high for exactly one cycle.
  - Back-to-back hits are accepted every cycle.
- `i_busy` rising in the same cycle as `i_hit_valid`: not accepted, because ready is combinational on `i_busy`.
- Asynchronous reset mid-hit: the ack is suppressed and the map rebuilds.

## Test plan
- Build: release reset, wait 30 cycles.
  - `o_init_done` rises on edge 30.
  - (0,10)=3, (5,5)=3, (1,3)=2, (4,3)=0, (39,29)=3, (2,2)=0.
- Read latency and out of range:
  - req (1,3) → `o_tile`=2 and `o_is_wall`=1 one cycle later.
  - req (45,2) → `o_tile`=3.
  - q (4,3) → `o_q_wall`=0.
- Brick destruction: hit (1,3) twice back-to-back.
  - Acks 2 consecutive cycles, absorbed=1 on both.
  - Tile 2→1→0.
  - Third hit: ack with absorbed=0.
- Steel and empty: hit (5,5) → absorbed=1, tile stays 3. Hit (2,2) → absorbed=0.
- Busy gating: hold `i_busy`=1 with `i_hit_valid`=1 for 10 cycles.
  - No ack, tile unchanged.
  - Drop busy → ack the next cycle.
- Reload mid-game and mid-build:
  - After destroying (1,3), pulse `i_reload` → `o_init_done`=0, and after 30 cycles (1,3)=2.
  - Pulse `i_reload` again at build row 12 → `o_init_done` rises 30 cycles after the second pulse.

Source files
------------

// File: rtl/map_server.sv
// map_server: destructible tile map with VGA/collision read ports and a shell-hit port
module map_server #(
  parameter int MAP_W = 40,
  parameter int MAP_H = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_reload,
  input  logic       i_busy,
  input  logic [5:0] i_req_x,
  input  logic [5:0] i_req_y,
  output logic       o_is_wall,
  output logic [1:0] o_tile,
  input  logic [5:0] i_q_x,
  input  logic [5:0] i_q_y,
  output logic       o_q_wall,
  input  logic       i_hit_valid,
  input  logic [5:0] i_hit_x,
  input  logic [5:0] i_hit_y,
  output logic       o_hit_ready,
  output logic       o_hit_ack,
  output logic       o_hit_absorbed,
  output logic       o_init_done
);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam logic [5:0] W6 = 6'(MAP_W);
  localparam logic [5:0] H6 = 6'(MAP_H);
  localparam logic [YW-1:0] LAST_ROW = YW'(MAP_H - 1);

  typedef enum logic {INIT, RUN} state_t;
  typedef logic [MAP_W-1:0][1:0] row_t;

  state_t          state, state_nx;
  logic [YW-1:0]   row, row_nx;
  logic            done_nx;
  row_t [MAP_H-1:0] map;
  logic [1:0]      hit_old;
  logic            hit_acc;

  // Initial layout of one row: steel border, steel pillars on a 10-tile grid, brick bands
  function automatic row_t row_pattern(input logic [YW-1:0] y);
    row_t r;
    int yi;
    yi = 32'(y);
    for (int x = 0; x < MAP_W; x++)
      r[x] = (x == 0 || yi == 0 || x == MAP_W - 1 || yi == MAP_H - 1) ? 2'd3 :
             (x % 10 == 5 && yi % 10 == 5) ? 2'd3 :
             (yi % 6 == 3 && x % 4 != 0) ? 2'd2 : 2'd0;
    return r;
  endfunction

  // Anything off the map behaves as indestructible steel
  function automatic logic [1:0] tile_at(input logic [5:0] x, input logic [5:0] y);
    return (x < W6 && y < H6) ? map[y[YW-1:0]][x[XW-1:0]] : 2'd3;
  endfunction

  assign o_hit_ready = state == RUN && !i_busy && !i_reload;
  assign hit_acc     = i_hit_valid && o_hit_ready;
  assign hit_old     = tile_at(i_hit_x, i_hit_y);
  assign o_is_wall   = o_tile != 2'd0;

  // Next state: reload always restarts the build; INIT walks rows then enters RUN
  always_comb begin
    state_nx = state;
    row_nx   = row;
    done_nx  = o_init_done;
    if (i_reload) begin
      state_nx = INIT;
      row_nx   = '0;
      done_nx  = 1'b0;
    end else if (state == INIT) begin
      row_nx   = row == LAST_ROW ? '0 : row + 1'b1;
      state_nx = row == LAST_ROW ? RUN : INIT;
      done_nx  = row == LAST_ROW;
    end
  end

  // FSM state, build row counter and done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      row         <= '0;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_nx;
      row         <= row_nx;
      o_init_done <= done_nx;
    end
  end

  // Map storage: one row per build cycle, or a brick losing one HP on an accepted hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      map <= '0;
    else if (state == INIT && !i_reload)
      map[row] <= row_pattern(row);
    else if (hit_acc && (hit_old == 2'd1 || hit_old == 2'd2))
      map[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]] <= hit_old - 2'd1;
  end

  // Registered read ports and hit response; reads see the pre-hit contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tile         <= 2'd0;
      o_q_wall       <= 1'b0;
      o_hit_ack      <= 1'b0;
      o_hit_absorbed <= 1'b0;
    end else begin
      o_tile         <= tile_at(i_req_x, i_req_y);
      o_q_wall       <= tile_at(i_q_x, i_q_y) != 2'd0;
      o_hit_ack      <= hit_acc;
      o_hit_absorbed <= hit_acc && hit_old != 2'd0;
    end
  end
endmodule

// File: tb/tb_map_server.sv
// tb_map_server: directed plan checks plus random traffic against a tile-array reference model
module tb_map_server;
  localparam int W = 40;
  localparam int H = 30;

  logic       clk = 0, rst_n = 0, reload = 0, busy = 0, hit_valid = 0;
  logic [5:0] req_x = 0, req_y = 0, q_x = 0, q_y = 0, hit_x = 0, hit_y = 0;
  logic       is_wall, q_wall, hit_ready, hit_ack, hit_absorbed, init_done;
  logic [1:0] tile;

  int n_chk = 0, n_fail = 0;
  int mem[H][W];
  bit m_done = 0;
  int m_row = 0;

  always #20 clk = ~clk;

  map_server #(.MAP_W(W), .MAP_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .i_reload(reload), .i_busy(busy),
    .i_req_x(req_x), .i_req_y(req_y), .o_is_wall(is_wall), .o_tile(tile),
    .i_q_x(q_x), .i_q_y(q_y), .o_q_wall(q_wall),
    .i_hit_valid(hit_valid), .i_hit_x(hit_x), .i_hit_y(hit_y),
    .o_hit_ready(hit_ready), .o_hit_ack(hit_ack), .o_hit_absorbed(hit_absorbed),
    .o_init_done(init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int build(int x, int y);
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return 3;
    if (x % 10 == 5 && y % 10 == 5) return 3;
    if (y % 6 == 3 && x % 4 != 0) return 2;
    return 0;
  endfunction

  function automatic int look(int x, int y);
    return (x >= W || y >= H) ? 3 : mem[y][x];
  endfunction

  task automatic step();
    int t, old;
    bit q, rdy, acc;
    #1;
    t   = look(int'(req_x), int'(req_y));
    q   = look(int'(q_x), int'(q_y)) != 0;
    rdy = m_done && !busy && !reload;
    chk("hit_ready", 32'(hit_ready), 32'(rdy));
    acc = hit_valid && rdy;
    old = look(int'(hit_x), int'(hit_y));
    if (acc && (old == 1 || old == 2)) mem[hit_y][hit_x] = old - 1;
    if (reload) begin
      m_done = 0;
      m_row  = 0;
    end else if (!m_done) begin
      for (int x = 0; x < W; x++) mem[m_row][x] = build(x, m_row);
      m_row++;
      if (m_row == H) m_done = 1;
    end
    @(posedge clk);
    #1;
    chk("tile", 32'(tile), 32'(t));
    chk("is_wall", 32'(is_wall), 32'(t != 0));
    chk("q_wall", 32'(q_wall), 32'(q));
    chk("hit_ack", 32'(hit_ack), 32'(acc));
    chk("hit_absorbed", 32'(hit_absorbed), 32'(acc && old != 0));
    chk("init_done", 32'(init_done), 32'(m_done));
  endtask

  task automatic probe(input int x, input int y, input int exp);
    req_x = 6'(x); req_y = 6'(y); q_x = 6'(x); q_y = 6'(y);
    step();
    chk($sformatf("probe_tile(%0d,%0d)", x, y), 32'(tile), 32'(exp));
    chk($sformatf("probe_q(%0d,%0d)", x, y), 32'(q_wall), 32'(exp != 0));
  endtask

  initial begin
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mem[y][x] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tile", 32'(tile), 0);
    chk("rst_is_wall", 32'(is_wall), 0);
    chk("rst_q_wall", 32'(q_wall), 0);
    chk("rst_ack", 32'(hit_ack), 0);
    chk("rst_absorbed", 32'(hit_absorbed), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_ready", 32'(hit_ready), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (29) step();
    chk("init_edge29", 32'(init_done), 0);
    step();
    chk("init_edge30", 32'(init_done), 1);

    probe(0, 10, 3); probe(5, 5, 3); probe(1, 3, 2);
    probe(4, 3, 0);  probe(39, 29, 3); probe(2, 2, 0);
    probe(45, 2, 3); probe(3, 33, 3);
    chk("wall_1_3", 32'(is_wall), 1);

    // back-to-back hits on (1,3) with a same-cycle read
    req_x = 1; req_y = 3; hit_x = 1; hit_y = 3; hit_valid = 1;
    step(); chk("b2b_read0", 32'(tile), 2); chk("b2b_ack0", 32'(hit_ack), 1); chk("b2b_abs0", 32'(hit_absorbed), 1);
    step(); chk("b2b_read1", 32'(tile), 1); chk("b2b_ack1", 32'(hit_ack), 1); chk("b2b_abs1", 32'(hit_absorbed), 1);
    step(); chk("b2b_read2", 32'(tile), 0); chk("b2b_ack2", 32'(hit_ack), 1); chk("b2b_abs2", 32'(hit_absorbed), 0);
    hit_valid = 0;
    step(); chk("b2b_noack", 32'(hit_ack), 0);

    hit_x = 5; hit_y = 5; hit_valid = 1;
    step(); chk("steel_abs", 32'(hit_absorbed), 1);
    hit_x = 2; hit_y = 2;
    step(); chk("empty_abs", 32'(hit_absorbed), 0);
    hit_x = 55; hit_y = 1;
    step(); chk("oor_abs", 32'(hit_absorbed), 1);
    hit_valid = 0;
    probe(5, 5, 3);

    // busy gating on brick (2,3)
    busy = 1; hit_valid = 1; hit_x = 2; hit_y = 3;
    repeat (10) begin
      step();
      chk("busy_noack", 32'(hit_ack), 0);
    end
    busy = 0;
    step(); chk("unbusy_ack", 32'(hit_ack), 1);
    hit_valid = 0;
    probe(2, 3, 1);

    // reload after destruction, then reload again mid-build
    reload = 1; step(); reload = 0;
    chk("reload_done0", 32'(init_done), 0);
    repeat (30) step();
    probe(1, 3, 2);
    reload = 1; step(); reload = 0;
    repeat (12) step();
    reload = 1; step(); reload = 0;
    repeat (29) step();
    chk("rebuild_edge29", 32'(init_done), 0);
    step();
    chk("rebuild_edge30", 32'(init_done), 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req_x = 6'($urandom_range(0, 44)); req_y = 6'($urandom_range(0, 34));
      q_x = 6'($urandom_range(0, 44));   q_y = 6'($urandom_range(0, 34));
      hit_x = 6'($urandom_range(0, 44));
      hit_y = ($urandom_range(0, 1) == 0) ? 6'(6 * $urandom_range(0, 4) + 3) : 6'($urandom_range(0, 34));
      hit_valid = $urandom_range(0, 1) == 1;
      busy = $urandom_range(0, 3) == 0;
      reload = $urandom_range(0, 199) == 0;
      step();
    end
    reload = 0; busy = 0; hit_valid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
